// File: rtl/tone_phase_engine.sv
// tone_phase_engine: multi-channel DDS phase front end.
// Converts a tone in Hz into a phase increment floor(tone * 2^PHASE_W / SAMPLE_RATE)
// using a restoring divider, and runs one phase accumulator per channel.
// Optional build macro TONE_PHASE_RESET_EN: a committed write also clears the
// target channel's accumulator (phase-coherent note start).
module tone_phase_engine #(
  parameter int NUM_CH      = 4,
  parameter int TONE_W      = 10,
  parameter int PHASE_W     = 32,
  parameter int SAMPLE_RATE = 48000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      sample_tick_in,
  input  logic                      cfg_valid_in,
  output logic                      cfg_ready_out,
  input  logic [CH_W-1:0]           cfg_ch_in,
  input  logic [TONE_W-1:0]         cfg_tone_in,
  output logic                      done_out,
  output logic                      err_out,
  output logic [NUM_CH*PHASE_W-1:0] phase_out
);

  // Numerator is tone << PHASE_W; the remainder never exceeds the divisor,
  // so one extra bit above the divisor width covers the shifted remainder.
  localparam int NUM_W = TONE_W + PHASE_W;
  localparam int REM_W = $clog2(SAMPLE_RATE) + 1;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [REM_W-1:0] DIVISOR   = REM_W'(SAMPLE_RATE);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_COMMIT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CH_W-1:0]    r_ch;
  logic               r_nyq;
  logic               r_bad_ch;
  logic [NUM_W-1:0]   r_num;      // numerator shifts out, quotient shifts in
  logic [REM_W-2:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_bad_ch;
  logic               w_nyquist;
  logic [REM_W-1:0]   w_shift;
  logic               w_fits;
  logic [REM_W-2:0]   w_rem_next;
  logic [PHASE_W-1:0] w_quot;

  assign w_accept   = cfg_valid_in && cfg_ready_out;
  assign w_bad_ch   = 32'(cfg_ch_in) >= 32'(NUM_CH);
  assign w_nyquist  = 32'({cfg_tone_in, 1'b0}) >= 32'(SAMPLE_RATE);
  assign w_shift    = {r_rem, r_num[NUM_W-1]};
  assign w_fits     = w_shift >= DIVISOR;
  assign w_rem_next = w_fits ? (REM_W-1)'(w_shift - DIVISOR) : w_shift[REM_W-2:0];
  assign w_quot     = r_num[PHASE_W-1:0];

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and handshake/status outputs
  always_comb begin
    w_state_next  = r_state;
    cfg_ready_out = 1'b0;
    done_out      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready_out = 1'b1;
        if (cfg_valid_in && !w_bad_ch)
          w_state_next = w_nyquist ? S_COMMIT : S_DIV;
      end
      S_DIV: begin
        if (r_cnt == '0) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        done_out     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A bad channel flags in the cycle after accept; Nyquist flags alongside its commit
  assign err_out = r_bad_ch || (done_out && r_nyq);

  // Latch the request at accept, then run one restoring-divide step per DIV cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ch     <= '0;
      r_nyq    <= 1'b0;
      r_bad_ch <= 1'b0;
      r_num    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else begin
      r_bad_ch <= w_accept && w_bad_ch;
      if (w_accept && !w_bad_ch) begin
        r_ch  <= cfg_ch_in;
        r_nyq <= w_nyquist;
        r_num <= w_nyquist ? '0 : {cfg_tone_in, {PHASE_W{1'b0}}};
        r_rem <= '0;
        r_cnt <= LAST_STEP;
      end else if (r_state == S_DIV) begin
        r_num <= {r_num[NUM_W-2:0], w_fits};
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Per-channel increment and accumulator; a tick in the commit cycle uses the old increment
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_inc;
    logic               w_hit;

    assign w_hit = done_out && (r_ch == CH_W'(gi));

    // Increment written at the end of COMMIT; accumulator advanced on each tick
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_inc <= '0;
        r_acc <= '0;
      end else begin
        if (w_hit) r_inc <= w_quot;
`ifdef TONE_PHASE_RESET_EN
        if (w_hit)               r_acc <= '0;
        else if (sample_tick_in) r_acc <= r_acc + r_inc;
`else
        if (sample_tick_in)      r_acc <= r_acc + r_inc;
`endif
      end
    end

    assign phase_out[gi*PHASE_W +: PHASE_W] = r_acc;
  end

endmodule

// File: tb/tb_tone_phase_engine.sv
// Testbench for tone_phase_engine: cycle-level reference model plus a
// scoreboard of expected done/err pulses keyed by cycle number.
module tb_tone_phase_engine;

  localparam int NCH  = 3;      // non power of two, so channel 3 is a bad channel
  localparam int TW   = 10;
  localparam int PW   = 32;
  localparam int SR   = 1500;
  localparam int NDIV = TW + PW;

  logic              clk = 1'b0;
  logic              rst_in;
  logic              sample_tick_in;
  logic              cfg_valid_in;
  logic              cfg_ready_out;
  logic [1:0]        cfg_ch_in;
  logic [TW-1:0]     cfg_tone_in;
  logic              done_out;
  logic              err_out;
  logic [NCH*PW-1:0] phase_out;

  tone_phase_engine #(
    .NUM_CH(NCH), .TONE_W(TW), .PHASE_W(PW), .SAMPLE_RATE(SR)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .sample_tick_in(sample_tick_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
    .cfg_ch_in(cfg_ch_in), .cfg_tone_in(cfg_tone_in),
    .done_out(done_out), .err_out(err_out), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected status pulses
  typedef struct {
    int cyc;
    bit done;
    bit err;
  } ev_t;
  ev_t sb[$];

  // Reference model state
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_acc[NCH];
  logic [31:0] m_inc[NCH];
  int          m_commit_at = -1;
  int          m_ch = 0;
  logic [31:0] m_new = '0;

  initial begin
    for (int k = 0; k < NCH; k++) begin
      m_acc[k] = '0;
      m_inc[k] = '0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Compare outputs mid-cycle, then advance the model across the coming edge
  always @(negedge clk) begin
    bit idle;
    if (mon_en) begin
      check_val("ready", {63'd0, cfg_ready_out}, {63'd0, m_commit_at < 0});
      for (int k = 0; k < NCH; k++)
        check_val($sformatf("phase_ch%0d", k), {32'd0, phase_out[k*PW +: PW]}, {32'd0, m_acc[k]});
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check_val($sformatf("done_at_%0d", cyc), {63'd0, done_out}, {63'd0, sb[0].done});
        check_val($sformatf("err_at_%0d", cyc), {63'd0, err_out}, {63'd0, sb[0].err});
        $display("cycle %0d: pulse done=%0b err=%0b (expected done=%0b err=%0b)",
                 cyc, done_out, err_out, sb[0].done, sb[0].err);
        void'(sb.pop_front());
      end else if (done_out || err_out) begin
        check_val($sformatf("stray_pulse_%0d", cyc), {62'd0, done_out, err_out}, 64'd0);
      end

      if (rst_in) begin
        for (int k = 0; k < NCH; k++) begin
          m_acc[k] = '0;
          m_inc[k] = '0;
        end
        m_commit_at = -1;
        sb.delete();
      end else begin
        idle = (m_commit_at < 0);
        if (sample_tick_in)
          for (int k = 0; k < NCH; k++) m_acc[k] = m_acc[k] + m_inc[k];
        if (m_commit_at == cyc) begin
          m_inc[m_ch] = m_new;
`ifdef TONE_PHASE_RESET_EN
          m_acc[m_ch] = '0;
`endif
          m_commit_at = -1;
        end
        if (cfg_valid_in && idle) begin
          if (int'(cfg_ch_in) >= NCH) begin
            sb.push_back('{cyc + 1, 1'b0, 1'b1});
          end else if (2 * int'(cfg_tone_in) >= SR) begin
            m_ch = int'(cfg_ch_in);
            m_new = '0;
            m_commit_at = cyc + 1;
            sb.push_back('{cyc + 1, 1'b1, 1'b1});
          end else begin
            m_ch = int'(cfg_ch_in);
            m_new = 32'((64'(cfg_tone_in) << 32) / 64'(SR));
            m_commit_at = cyc + NDIV + 1;
            sb.push_back('{cyc + NDIV + 1, 1'b1, 1'b0});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_commit_at >= 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check_val("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic write(input int ch, input int tone);
    wait_idle();
    cfg_valid_in = 1'b1;
    cfg_ch_in    = 2'(ch);
    cfg_tone_in  = TW'(tone);
    step();
    cfg_valid_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    sample_tick_in = 1'b1;
    repeat (n) step();
    sample_tick_in = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    cfg_valid_in = 1'b0;
    cfg_ch_in = '0;
    cfg_tone_in = '0;
    repeat (3) step();
    rst_in = 1'b0;
    mon_en = 1'b1;

    // Idle ticks: nothing moves
    ticks(5);
    step();

    // Normal write, then three ticks
    write(1, 440);
    wait_idle();
    ticks(3);
    step();

    // Exact quarter-turn increment; five ticks wrap past 2^32
    write(0, 375);
    wait_idle();
    ticks(5);
    step();

    // Nyquist boundary, just below it, and a bad channel
    write(2, 750);
    write(3, 100);
    write(2, 749);
    wait_idle();
    ticks(2);

    // Tick every cycle across a tone change on ch0, including the commit cycle
    write(0, 700);
    wait_idle();
    sample_tick_in = 1'b1;
    write(0, 440);
    wait_idle();
    repeat (3) step();
    // Nyquist commit under continuous ticking, same-tone rewrite, tone 0
    write(1, 1000);
    write(1, 440);
    write(1, 440);
    write(2, 0);
    wait_idle();
    step();
    sample_tick_in = 1'b0;

    // Randomised writes and tick bursts
    repeat (8) begin
      write(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
      wait_idle();
      ticks(int'($urandom_range(0, 3)));
    end

    // Valid held with changing data during DIV, then reset mid-division
    wait_idle();
    cfg_valid_in = 1'b1;
    cfg_ch_in = 2'd1;
    cfg_tone_in = 10'd300;
    step();
    repeat (15) begin
      cfg_ch_in = 2'($urandom_range(0, 2));
      cfg_tone_in = TW'($urandom_range(0, 700));
      sample_tick_in = 1'($urandom_range(0, 1));
      step();
    end
    rst_in = 1'b1;
    cfg_valid_in = 1'b0;
    sample_tick_in = 1'b0;
    step();
    rst_in = 1'b0;
    repeat (NDIV + 4) step();
    ticks(4);

    // Recovery after reset
    write(1, 440);
    wait_idle();
    ticks(2);
    repeat (3) step();

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
